vga_layer_scheduler: RTL and testbench
======================================

# vga_layer_scheduler

Screen sequencer and layer arbiter for the VGA pixel path. It steps the display through logo, house-select, gameplay and leaderboard screens, changing screen only at frame boundaries. Per pixel, it chooses one palette index from the layer sources (logo, crest, score digits, cursor, traced box, background) by a fixed per-screen priority. It replaces the multi-driven index nets in front of the palette ROM (img_index) with one registered 8-bit index.

## Interface
- LOGO_FRAMES, 300: frames the opening logo is shown (5 s at 60 Hz).
- FRAME_W, 9: frame counter width; must satisfy 2^FRAME_W > LOGO_FRAMES.
- iVGA_CLK  in  1  pixel clock.
- iRST_n  in  1  reset; asynchronous, active-low.
- cVS  in  1  vertical sync from video_sync_generator, active-low.
- cBLANK_n  in  1  active-video flag, same cycle as pixel requests.
- house_sel  in  4  {G,S,H,R} house switches.
- leaderboard  in  1  leaderboard request level.
- logo_v, crest_v, num_v, cursor_v, trace_v  in  1 each  layer pixel-valid flags.
- logo_idx, crest_idx, num_idx, cursor_idx, trace_idx, bg_idx  in  8 each  layer palette indices.
- file_index  out  8  registered palette index to img_index.
- src_id  out  3  registered winning source: 0 none/blank, 1 bg, 2 crest, 3 num, 4 trace, 5 cursor, 6 logo.
- screen  out  2  current screen: 0 LOGO, 1 SELECT, 2 GAME, 3 LEADER.
- logo_en, crest_en, num_en, trace_en  out  1 each  per-screen enables to the layer generators. They are decoded from `screen` and change at the same time as `screen`.

## Operation
- Frame start (`fs`) is a one-cycle pulse on the cycle after cVS is sampled going from 1 to 0. A 2-flop history register provides the previous value.
- FSM. The state is evaluated only on a cycle where `fs`=1.
  - LOGO: exit to SELECT when frame_cnt == LOGO_FRAMES-1.
  - SELECT: exit to GAME when house_sel is exactly one-hot. 0 bits or 2 or more bits set keeps the FSM in SELECT.
  - GAME: exit to LEADER when leaderboard=1.
  - LEADER: exit to GAME when leaderboard=0.
  - There are no other transitions. A house_sel change during GAME or LEADER does not change the screen.
- frame_cnt increments on `fs` only while in LOGO. It clears to 0 on the LOGO exit and is held at 0 outside LOGO.
- Enables:
  - LOGO: logo_en only.
  - SELECT: crest_en only.
  - GAME: crest_en, num_en and trace_en.
  - LEADER: crest_en and num_en.
- Priority by screen, highest first. The first source whose valid flag is set wins; bg has no valid flag and always qualifies.
  - LOGO: logo, else index 0.
  - SELECT: crest, then bg.
  - GAME: cursor, then trace, then num, then crest, then bg.
  - LEADER: num, then crest, then bg.
- Valid flags of sources not listed for the current screen are ignored.
- When cBLANK_n=0, file_index=0 and src_id=0, regardless of any valid flags.

## Timing
- Reset values: screen=LOGO, frame_cnt=0, file_index=8'd0, src_id=0, logo_en=1, all other enables 0, cVS history=1.
- Reset is honoured at any point mid-frame. The display restarts at LOGO, and the next `fs` counts as logo frame 0.
- Pixel latency is 1 cycle: inputs sampled at edge N appear on file_index and src_id after edge N. Pixel position alignment belongs to the layer generators.
- A screen change takes effect on the cycle after `fs`. Pixels in that cycle already use the new priority table. No mid-frame change of priority or enables is allowed.
- A leaderboard pulse that both rises and falls between two `fs` pulses is not acted on.

## Structure
- Package vga_sched_pkg holds the screen encoding (LOGO/SELECT/GAME/LEADER), the src_id constants (0..6), and the width constant IDX_W=8.
- Sub-module vga_priority_mux is combinational. It takes the screen, cBLANK_n, all valid flags and all indices, and returns the next index and src_id. The top level registers its outputs.
- The FSM, `fs` detector and frame counter live in the top level.

## Test plan
- Reset, then 300 cVS falling edges with LOGO_FRAMES=300 and logo_v=1, logo_idx=8'h21 -> file_index=8'h21 while in LOGO; screen=SELECT on the cycle after the 300th `fs`.
- In SELECT, house_sel=4'b1010 for 3 frames, then 4'b1000 -> screen stays SELECT for those 3 frames, then becomes GAME after the next `fs`.
- In GAME, cursor_v=trace_v=num_v=crest_v=1 with indices 5, 6, 7, 8 and bg_idx=9 -> file_index=5, src_id=5. Dropping each valid in turn gives 6/4, then 7/3, then 8/2, then 9/1.
- In GAME, leaderboard=1 mid-frame with trace_v=1 (trace_idx=6), num_v=0, crest_v=0, bg_idx=9 -> file_index stays 6 until `fs`. After `fs`, screen=LEADER, trace_en=0, and file_index=bg_idx=9. A leaderboard pulse of fewer than one frame, wholly between two `fs` pulses, produces no screen change.
- cBLANK_n=0 with every valid flag set -> file_index=0 and src_id=0 one cycle later.
- Assert iRST_n=0 mid-frame in LEADER -> outputs go to reset values immediately (asynchronous). After release, screen=LOGO and frame_cnt=0.

Source files
------------

// File: rtl/vga_sched_pkg.sv
// Shared encodings for the VGA screen sequencer and layer arbiter:
// screen states, winning-source identifiers and the palette index width.
package vga_sched_pkg;

  localparam int IDX_W = 8;

  typedef enum logic [1:0] {
    SCR_LOGO   = 2'd0,
    SCR_SELECT = 2'd1,
    SCR_GAME   = 2'd2,
    SCR_LEADER = 2'd3
  } screen_e;

  localparam logic [2:0] SRC_NONE   = 3'd0;
  localparam logic [2:0] SRC_BG     = 3'd1;
  localparam logic [2:0] SRC_CREST  = 3'd2;
  localparam logic [2:0] SRC_NUM    = 3'd3;
  localparam logic [2:0] SRC_TRACE  = 3'd4;
  localparam logic [2:0] SRC_CURSOR = 3'd5;
  localparam logic [2:0] SRC_LOGO   = 3'd6;

  // True when exactly one house switch is set.
  function automatic logic is_onehot4(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

endpackage

// File: rtl/vga_priority_mux.sv
// Combinational per-screen layer arbiter: picks the highest-priority valid
// layer for the current screen; blanking forces index 0 / source none.
module vga_priority_mux
  import vga_sched_pkg::*;
(
  input  logic [1:0]       screen_i,
  input  logic             blank_n_i,
  input  logic             logo_v_i,
  input  logic             crest_v_i,
  input  logic             num_v_i,
  input  logic             cursor_v_i,
  input  logic             trace_v_i,
  input  logic [IDX_W-1:0] logo_idx_i,
  input  logic [IDX_W-1:0] crest_idx_i,
  input  logic [IDX_W-1:0] num_idx_i,
  input  logic [IDX_W-1:0] cursor_idx_i,
  input  logic [IDX_W-1:0] trace_idx_i,
  input  logic [IDX_W-1:0] bg_idx_i,
  output logic [IDX_W-1:0] idx_o,
  output logic [2:0]       src_o
);

  // Priority selection; sources not listed for a screen are never consulted.
  always_comb begin
    idx_o = {IDX_W{1'b0}};
    src_o = SRC_NONE;
    if (!blank_n_i) begin
      idx_o = {IDX_W{1'b0}};
      src_o = SRC_NONE;
    end else begin
      case (screen_e'(screen_i))
        SCR_LOGO: begin
          if (logo_v_i) begin
            idx_o = logo_idx_i;  src_o = SRC_LOGO;
          end else begin
            idx_o = {IDX_W{1'b0}};  src_o = SRC_NONE;
          end
        end
        SCR_SELECT: begin
          if (crest_v_i) begin
            idx_o = crest_idx_i;  src_o = SRC_CREST;
          end else begin
            idx_o = bg_idx_i;  src_o = SRC_BG;
          end
        end
        SCR_GAME: begin
          if (cursor_v_i) begin
            idx_o = cursor_idx_i;  src_o = SRC_CURSOR;
          end else if (trace_v_i) begin
            idx_o = trace_idx_i;  src_o = SRC_TRACE;
          end else if (num_v_i) begin
            idx_o = num_idx_i;  src_o = SRC_NUM;
          end else if (crest_v_i) begin
            idx_o = crest_idx_i;  src_o = SRC_CREST;
          end else begin
            idx_o = bg_idx_i;  src_o = SRC_BG;
          end
        end
        SCR_LEADER: begin
          if (num_v_i) begin
            idx_o = num_idx_i;  src_o = SRC_NUM;
          end else if (crest_v_i) begin
            idx_o = crest_idx_i;  src_o = SRC_CREST;
          end else begin
            idx_o = bg_idx_i;  src_o = SRC_BG;
          end
        end
        default: begin
          idx_o = {IDX_W{1'b0}};  src_o = SRC_NONE;
        end
      endcase
    end
  end

endmodule

// File: rtl/vga_layer_scheduler.sv
// Screen sequencer (frame-boundary FSM, logo frame counter) and registered
// palette index selection for the VGA pixel path.
module vga_layer_scheduler
  import vga_sched_pkg::*;
#(
  parameter int LOGO_FRAMES = 300,
  parameter int FRAME_W     = 9
) (
  input  logic             iVGA_CLK,
  input  logic             iRST_n,
  input  logic             cVS,
  input  logic             cBLANK_n,
  input  logic [3:0]       house_sel,
  input  logic             leaderboard,
  input  logic             logo_v,
  input  logic             crest_v,
  input  logic             num_v,
  input  logic             cursor_v,
  input  logic             trace_v,
  input  logic [IDX_W-1:0] logo_idx,
  input  logic [IDX_W-1:0] crest_idx,
  input  logic [IDX_W-1:0] num_idx,
  input  logic [IDX_W-1:0] cursor_idx,
  input  logic [IDX_W-1:0] trace_idx,
  input  logic [IDX_W-1:0] bg_idx,
  output logic [IDX_W-1:0] file_index,
  output logic [2:0]       src_id,
  output logic [1:0]       screen,
  output logic             logo_en,
  output logic             crest_en,
  output logic             num_en,
  output logic             trace_en
);

  localparam logic [FRAME_W-1:0] CNT_LAST = FRAME_W'(LOGO_FRAMES - 1);
  localparam logic [FRAME_W-1:0] CNT_ONE  = FRAME_W'(1);
  localparam logic [FRAME_W-1:0] CNT_ZERO = {FRAME_W{1'b0}};

  logic [1:0]         cvs_hist_q;
  logic               fs_s;
  screen_e            state_q, state_d;
  logic [FRAME_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [3:0]         en_d, en_q;
  logic [IDX_W-1:0]   idx_d, file_index_q;
  logic [2:0]         src_d, src_id_q;

  // Frame start: previous sample high, newest sample low.
  assign fs_s = cvs_hist_q[1] & ~cvs_hist_q[0];

  // Next screen and logo frame count; only acted on at a frame start.
  always_comb begin
    state_d     = state_q;
    frame_cnt_d = frame_cnt_q;
    if (fs_s) begin
      case (state_q)
        SCR_LOGO: begin
          if (frame_cnt_q == CNT_LAST) begin
            state_d     = SCR_SELECT;
            frame_cnt_d = CNT_ZERO;
          end else begin
            frame_cnt_d = frame_cnt_q + CNT_ONE;
          end
        end
        SCR_SELECT: begin
          frame_cnt_d = CNT_ZERO;
          if (is_onehot4(house_sel)) state_d = SCR_GAME;
          else                       state_d = SCR_SELECT;
        end
        SCR_GAME: begin
          frame_cnt_d = CNT_ZERO;
          if (leaderboard) state_d = SCR_LEADER;
          else             state_d = SCR_GAME;
        end
        SCR_LEADER: begin
          frame_cnt_d = CNT_ZERO;
          if (!leaderboard) state_d = SCR_GAME;
          else              state_d = SCR_LEADER;
        end
        default: begin
          state_d     = SCR_LOGO;
          frame_cnt_d = CNT_ZERO;
        end
      endcase
    end else begin
      state_d     = state_q;
      frame_cnt_d = frame_cnt_q;
    end
  end

  // Enables decoded from the next screen so they register alongside it: {logo,crest,num,trace}.
  always_comb begin
    en_d = 4'b1000;
    case (state_d)
      SCR_LOGO:   en_d = 4'b1000;
      SCR_SELECT: en_d = 4'b0100;
      SCR_GAME:   en_d = 4'b0111;
      SCR_LEADER: en_d = 4'b0110;
      default:    en_d = 4'b1000;
    endcase
  end

  vga_priority_mux u_mux (
    .screen_i     (state_q),
    .blank_n_i    (cBLANK_n),
    .logo_v_i     (logo_v),
    .crest_v_i    (crest_v),
    .num_v_i      (num_v),
    .cursor_v_i   (cursor_v),
    .trace_v_i    (trace_v),
    .logo_idx_i   (logo_idx),
    .crest_idx_i  (crest_idx),
    .num_idx_i    (num_idx),
    .cursor_idx_i (cursor_idx),
    .trace_idx_i  (trace_idx),
    .bg_idx_i     (bg_idx),
    .idx_o        (idx_d),
    .src_o        (src_d)
  );

  // State, counter, sync history and registered pixel outputs.
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      cvs_hist_q   <= 2'b11;
      state_q      <= SCR_LOGO;
      frame_cnt_q  <= CNT_ZERO;
      en_q         <= 4'b1000;
      file_index_q <= {IDX_W{1'b0}};
      src_id_q     <= SRC_NONE;
    end else begin
      cvs_hist_q   <= {cvs_hist_q[0], cVS};
      state_q      <= state_d;
      frame_cnt_q  <= frame_cnt_d;
      en_q         <= en_d;
      file_index_q <= idx_d;
      src_id_q     <= src_d;
    end
  end

  assign file_index = file_index_q;
  assign src_id     = src_id_q;
  assign screen     = state_q;
  assign logo_en    = en_q[3];
  assign crest_en   = en_q[2];
  assign num_en     = en_q[1];
  assign trace_en   = en_q[0];

endmodule

// File: tb/tb_vga_layer_scheduler.sv
// Directed-vector bench for vga_layer_scheduler with hand-computed expectations.
module tb_vga_layer_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cvs, blank_n, leaderboard;
  logic [3:0] house_sel;
  logic       logo_v, crest_v, num_v, cursor_v, trace_v;
  logic [7:0] logo_idx, crest_idx, num_idx, cursor_idx, trace_idx, bg_idx;
  logic [7:0] file_index;
  logic [2:0] src_id;
  logic [1:0] screen;
  logic       logo_en, crest_en, num_en, trace_en;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  vga_layer_scheduler #(.LOGO_FRAMES(300), .FRAME_W(9)) dut (
    .iVGA_CLK   (clk),
    .iRST_n     (rst_n),
    .cVS        (cvs),
    .cBLANK_n   (blank_n),
    .house_sel  (house_sel),
    .leaderboard(leaderboard),
    .logo_v     (logo_v),
    .crest_v    (crest_v),
    .num_v      (num_v),
    .cursor_v   (cursor_v),
    .trace_v    (trace_v),
    .logo_idx   (logo_idx),
    .crest_idx  (crest_idx),
    .num_idx    (num_idx),
    .cursor_idx (cursor_idx),
    .trace_idx  (trace_idx),
    .bg_idx     (bg_idx),
    .file_index (file_index),
    .src_id     (src_id),
    .screen     (screen),
    .logo_en    (logo_en),
    .crest_en   (crest_en),
    .num_en     (num_en),
    .trace_en   (trace_en)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One cVS low pulse; fs is high after the first edge, acted on at the second.
  task automatic frame();
    cvs = 1'b0;
    tick();
    tick();
    cvs = 1'b1;
    tick();
    tick();
  endtask

  task automatic check_en(input string tag, input logic [3:0] exp);
    check_val(tag, {logo_en, crest_en, num_en, trace_en}, exp);
  endtask

  initial begin
    rst_n = 1'b0; cvs = 1'b1; blank_n = 1'b1; leaderboard = 1'b0; house_sel = 4'b0000;
    logo_v = 1'b1; crest_v = 1'b0; num_v = 1'b0; cursor_v = 1'b0; trace_v = 1'b0;
    logo_idx = 8'h21; crest_idx = 8'd8; num_idx = 8'd7; cursor_idx = 8'd5;
    trace_idx = 8'd6; bg_idx = 8'd9;
    tick();
    check_val("rst_screen", screen, 2'd0);
    check_val("rst_index", file_index, 8'd0);
    check_val("rst_src", src_id, 3'd0);
    check_en("rst_en", 4'b1000);
    check_val("rst_cnt", dut.frame_cnt_q, 9'd0);
    rst_n = 1'b1;
    tick();
    tick();
    check_val("logo_index", file_index, 8'h21);
    check_val("logo_src", src_id, 3'd6);

    for (int i = 0; i < 299; i++) frame();
    check_val("logo_299_screen", screen, 2'd0);
    check_val("logo_299_cnt", dut.frame_cnt_q, 9'd299);
    check_val("logo_299_index", file_index, 8'h21);
    cvs = 1'b0;
    tick();
    check_val("fs_not_yet", screen, 2'd0);
    tick();
    check_val("select_entry", screen, 2'd1);
    check_en("select_en", 4'b0100);
    check_val("select_cnt", dut.frame_cnt_q, 9'd0);
    cvs = 1'b1;
    tick();
    check_val("select_bg_index", file_index, 8'd9);
    check_val("select_bg_src", src_id, 3'd1);

    house_sel = 4'b1010;
    for (int i = 0; i < 3; i++) begin
      frame();
      check_val("select_two_hot", screen, 2'd1);
    end
    house_sel = 4'b1000;
    frame();
    check_val("game_entry", screen, 2'd2);
    check_en("game_en", 4'b0111);
    house_sel = 4'b0001;
    frame();
    check_val("game_house_ignored", screen, 2'd2);

    logo_v = 1'b1; cursor_v = 1'b1; trace_v = 1'b1; num_v = 1'b1; crest_v = 1'b1;
    tick();
    check_val("game_cursor_idx", file_index, 8'd5);
    check_val("game_cursor_src", src_id, 3'd5);
    cursor_v = 1'b0; tick();
    check_val("game_trace_idx", file_index, 8'd6);
    check_val("game_trace_src", src_id, 3'd4);
    trace_v = 1'b0; tick();
    check_val("game_num_idx", file_index, 8'd7);
    check_val("game_num_src", src_id, 3'd3);
    num_v = 1'b0; tick();
    check_val("game_crest_idx", file_index, 8'd8);
    check_val("game_crest_src", src_id, 3'd2);
    crest_v = 1'b0; tick();
    check_val("game_bg_idx", file_index, 8'd9);
    check_val("game_bg_src", src_id, 3'd1);

    leaderboard = 1'b1;
    tick(); tick();
    leaderboard = 1'b0;
    tick();
    frame();
    check_val("short_pulse_ignored", screen, 2'd2);

    trace_v = 1'b1;
    leaderboard = 1'b1;
    tick(); tick();
    check_val("midframe_trace", file_index, 8'd6);
    cvs = 1'b0;
    tick();
    check_val("pre_fs_trace", file_index, 8'd6);
    tick();
    check_val("leader_entry", screen, 2'd3);
    check_en("leader_en", 4'b0110);
    cvs = 1'b1;
    tick();
    check_val("leader_bg_idx", file_index, 8'd9);
    check_val("leader_bg_src", src_id, 3'd1);
    num_v = 1'b1; crest_v = 1'b1; tick();
    check_val("leader_num_idx", file_index, 8'd7);
    check_val("leader_num_src", src_id, 3'd3);

    blank_n = 1'b0; cursor_v = 1'b1; logo_v = 1'b1;
    tick();
    check_val("blank_idx", file_index, 8'd0);
    check_val("blank_src", src_id, 3'd0);
    blank_n = 1'b1;

    leaderboard = 1'b0;
    frame();
    check_val("leader_to_game", screen, 2'd2);
    leaderboard = 1'b1;
    frame();
    check_val("game_to_leader", screen, 2'd3);

    cvs = 1'b0;
    tick();
    #2 rst_n = 1'b0;
    #1;
    check_val("async_rst_screen", screen, 2'd0);
    check_val("async_rst_idx", file_index, 8'd0);
    check_val("async_rst_src", src_id, 3'd0);
    check_en("async_rst_en", 4'b1000);
    cvs = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();
    check_val("post_rst_screen", screen, 2'd0);
    check_val("post_rst_cnt", dut.frame_cnt_q, 9'd0);
    frame();
    check_val("post_rst_first_frame", dut.frame_cnt_q, 9'd1);
    check_val("post_rst_logo_idx", file_index, 8'h21);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
